// File: rtl/bsg_axil_heartbeat_master.sv
// AXI4-Lite write-only heartbeat master: on every period tick it writes a running
// sequence number to each enabled channel address and tracks responses and stalls.
module bsg_axil_heartbeat_master #(
    parameter int channels_p        = 2,
    parameter int period_width_p    = 32,
    parameter int seq_width_p       = 16,
    parameter int resp_timeout_p    = 1024,
    parameter int cnt_width_p       = 8,
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    enable_i,
    input  logic [period_width_p-1:0]               period_i,
    input  logic [channels_p*axil_addr_width_p-1:0] addr_i,
    input  logic [channels_p-1:0]                   chan_mask_i,
    output logic [axil_addr_width_p-1:0]            m_axil_awaddr_o,
    output logic [2:0]                              m_axil_awprot_o,
    output logic                                    m_axil_awvalid_o,
    input  logic                                    m_axil_awready_i,
    output logic [axil_data_width_p-1:0]            m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0]          m_axil_wstrb_o,
    output logic                                    m_axil_wvalid_o,
    input  logic                                    m_axil_wready_i,
    input  logic [1:0]                              m_axil_bresp_i,
    input  logic                                    m_axil_bvalid_i,
    output logic                                    m_axil_bready_o,
    output logic [seq_width_p-1:0]                  seq_o,
    output logic [cnt_width_p-1:0]                  err_cnt_o,
    output logic [cnt_width_p-1:0]                  missed_cnt_o,
    output logic                                    timeout_o,
    output logic                                    busy_o
);

    localparam int ch_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1;
    localparam int to_width_lp = $clog2(resp_timeout_p + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ADV} state_e;

    state_e                        state_q, state_d;
    logic [period_width_p-1:0]     per_cnt_q, per_cnt_d;
    logic [period_width_p-1:0]     per_max;
    logic                          tick;
    logic [channels_p-1:0]         mask_q, mask_d;
    logic [ch_width_lp-1:0]        ch_q, ch_d;
    logic [seq_width_p-1:0]        seq_r_q, seq_r_d;
    logic [seq_width_p-1:0]        seq_q, seq_d;
    logic [cnt_width_p-1:0]        err_q, err_d;
    logic [cnt_width_p-1:0]        missed_q, missed_d;
    logic                          timeout_q, timeout_d;
    logic                          aw_done_q, aw_done_d;
    logic                          w_done_q, w_done_d;
    logic [to_width_lp-1:0]        to_cnt_q, to_cnt_d;
    logic [ch_width_lp-1:0]        first_ch;
    logic [ch_width_lp-1:0]        next_ch;
    logic                          next_found;
    logic                          aw_fire, w_fire;
    logic [axil_data_width_p-1:0]  wdata_ext;
    logic [axil_addr_width_p-1:0]  addr_arr [channels_p];

    genvar gi;
    generate
        for (gi = 0; gi < channels_p; gi++) begin : g_addr
            assign addr_arr[gi] = addr_i[gi*axil_addr_width_p +: axil_addr_width_p];
        end
    endgenerate

    // Live compare against the current max so a lowered period wraps immediately.
    always_comb begin
        per_max = (period_i == '0) ? '0 : period_i - period_width_p'(1);
        tick    = enable_i && (per_cnt_q >= per_max);
        if (!enable_i || tick) begin
            per_cnt_d = '0;
        end else begin
            per_cnt_d = per_cnt_q + period_width_p'(1);
        end
    end

    // Descending scans: the last hit is the lowest qualifying channel.
    always_comb begin
        first_ch   = '0;
        next_ch    = '0;
        next_found = 1'b0;
        for (int i = channels_p - 1; i >= 0; i--) begin
            if (chan_mask_i[i]) begin
                first_ch = ch_width_lp'(i);
            end
            if (mask_q[i] && (i > int'(ch_q))) begin
                next_ch    = ch_width_lp'(i);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        mask_d           = mask_q;
        ch_d             = ch_q;
        seq_r_d          = seq_r_q;
        seq_d            = seq_q;
        err_d            = err_q;
        missed_d         = missed_q;
        timeout_d        = timeout_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        to_cnt_d         = to_cnt_q;
        m_axil_awvalid_o = 1'b0;
        m_axil_wvalid_o  = 1'b0;
        m_axil_bready_o  = 1'b0;
        aw_fire          = 1'b0;
        w_fire           = 1'b0;

        if (tick && (state_q != IDLE) && (missed_q != '1)) begin
            missed_d = missed_q + cnt_width_p'(1);
        end

        // A response landing on the expiry cycle wins over the timeout.
        if ((state_q == ISSUE) || (state_q == RESP)) begin
            if (to_cnt_q != to_width_lp'(resp_timeout_p)) begin
                to_cnt_d = to_cnt_q + to_width_lp'(1);
            end else if (!((state_q == RESP) && m_axil_bvalid_i)) begin
                timeout_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (tick && (chan_mask_i != '0)) begin
                    mask_d    = chan_mask_i;
                    ch_d      = first_ch;
                    seq_r_d   = seq_r_q + seq_width_p'(1);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    to_cnt_d  = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                m_axil_awvalid_o = !aw_done_q;
                m_axil_wvalid_o  = !w_done_q;
                aw_fire          = m_axil_awvalid_o && m_axil_awready_i;
                w_fire           = m_axil_wvalid_o && m_axil_wready_i;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = RESP;
                end else begin
                    aw_done_d = aw_done_q || aw_fire;
                    w_done_d  = w_done_q || w_fire;
                end
            end
            RESP: begin
                m_axil_bready_o = 1'b1;
                if (m_axil_bvalid_i) begin
                    if ((m_axil_bresp_i != 2'b00) && (err_q != '1)) begin
                        err_d = err_q + cnt_width_p'(1);
                    end
                    state_d = ADV;
                end
            end
            ADV: begin
                to_cnt_d = '0;
                if (next_found) begin
                    ch_d    = next_ch;
                    state_d = ISSUE;
                end else begin
                    seq_d   = seq_r_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wdata_ext                  = '0;
        wdata_ext[seq_width_p-1:0] = seq_r_q;
    end

    // Payload is gated by valid so the bus reads all-zero whenever idle.
    assign m_axil_awaddr_o = m_axil_awvalid_o ? addr_arr[ch_q] : '0;
    assign m_axil_awprot_o = 3'b000;
    assign m_axil_wdata_o  = m_axil_wvalid_o ? wdata_ext : '0;
    assign m_axil_wstrb_o  = m_axil_wvalid_o ? '1 : '0;
    assign seq_o           = seq_q;
    assign err_cnt_o       = err_q;
    assign missed_cnt_o    = missed_q;
    assign timeout_o       = timeout_q;
    assign busy_o          = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            mask_q    <= '0;
            ch_q      <= '0;
            seq_r_q   <= '0;
            seq_q     <= '0;
            err_q     <= '0;
            missed_q  <= '0;
            timeout_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            seq_r_q   <= seq_r_d;
            seq_q     <= seq_d;
            err_q     <= err_d;
            missed_q  <= missed_d;
            timeout_q <= timeout_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: tb/tb_bsg_axil_heartbeat_master.sv
// Directed bench for bsg_axil_heartbeat_master with a simple AXI-Lite slave whose
// ready/response latencies and error injection are set per scenario.
module tb_bsg_axil_heartbeat_master;

    localparam logic [31:0] ADDR0 = 32'h1000_0000;
    localparam logic [31:0] ADDR1 = 32'h2000_0040;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] period = 32'd10;
    logic [63:0] addr = 64'd0;
    logic [1:0]  mask = 2'b00;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [15:0] seq;
    logic [7:0]  err_cnt;
    logic [7:0]  missed_cnt;
    logic        timeout;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int aw_delay = 0;
    int w_delay = 0;
    int b_delay = 0;
    bit err_ch1 = 1'b0;
    int aw_wait = 0;
    int w_wait = 0;
    int b_wait = 0;
    logic [31:0] last_aw = 32'd0;
    logic [31:0] last_w = 32'd0;

    logic [31:0] aw_log[$];
    int          aw_hold_log[$];
    int          aw_cyc_log[$];
    logic [31:0] w_log[$];
    int          w_hold_log[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bsg_axil_heartbeat_master #(
        .channels_p(2),
        .period_width_p(32),
        .seq_width_p(16),
        .resp_timeout_p(16),
        .cnt_width_p(8),
        .axil_data_width_p(32),
        .axil_addr_width_p(32)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .enable_i(enable),
        .period_i(period),
        .addr_i(addr),
        .chan_mask_i(mask),
        .m_axil_awaddr_o(awaddr),
        .m_axil_awprot_o(awprot),
        .m_axil_awvalid_o(awvalid),
        .m_axil_awready_i(awready),
        .m_axil_wdata_o(wdata),
        .m_axil_wstrb_o(wstrb),
        .m_axil_wvalid_o(wvalid),
        .m_axil_wready_i(wready),
        .m_axil_bresp_i(bresp),
        .m_axil_bvalid_i(bvalid),
        .m_axil_bready_o(bready),
        .seq_o(seq),
        .err_cnt_o(err_cnt),
        .missed_cnt_o(missed_cnt),
        .timeout_o(timeout),
        .busy_o(busy)
    );

    // Slave: readies are raised after a programmable number of valid cycles;
    // handshakes are logged here since they complete at the following posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_wait = 0; w_wait = 0; b_wait = 0;
        end else begin
            if (awvalid) begin
                if (aw_wait >= aw_delay) begin
                    awready = 1'b1;
                    aw_log.push_back(awaddr);
                    aw_hold_log.push_back(aw_wait + 1);
                    aw_cyc_log.push_back(cyc);
                    last_aw = awaddr;
                    aw_wait = 0;
                end else begin
                    awready = 1'b0;
                    aw_wait++;
                end
            end else begin
                awready = 1'b0;
                aw_wait = 0;
            end
            if (wvalid) begin
                if (w_wait >= w_delay) begin
                    wready = 1'b1;
                    w_log.push_back(wdata);
                    w_hold_log.push_back(w_wait + 1);
                    last_w = wdata;
                    w_wait = 0;
                end else begin
                    wready = 1'b0;
                    w_wait++;
                end
            end else begin
                wready = 1'b0;
                w_wait = 0;
            end
            if (bready) begin
                if (b_wait >= b_delay) begin
                    bvalid = 1'b1;
                    bresp = (err_ch1 && (last_aw == ADDR1)) ? 2'b10 : 2'b00;
                    b_wait = 0;
                    $display("txn cyc=%0d addr=%h data=%0d bresp=%0d", cyc, last_aw, last_w, bresp);
                end else begin
                    bvalid = 1'b0;
                    bresp = 2'b00;
                    b_wait++;
                end
            end else begin
                bvalid = 1'b0;
                b_wait = 0;
            end
        end
    end

    task automatic clear_logs();
        aw_log.delete(); aw_hold_log.delete(); aw_cyc_log.delete();
        w_log.delete(); w_hold_log.delete();
    endtask

    task automatic wait_writes(input int target, input int budget, output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if ((w_log.size() >= target) && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; period = 32'd10; mask = 2'b00;
        addr = {ADDR1, ADDR0};
        repeat (3) @(negedge clk);
        total++; if (awvalid !== 1'b0) begin bad++; $display("FAIL reset_awvalid: got %b want 0", awvalid); end
        total++; if (wvalid !== 1'b0) begin bad++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
        total++; if (bready !== 1'b0) begin bad++; $display("FAIL reset_bready: got %b want 0", bready); end
        total++; if ({awaddr, wdata, wstrb, awprot} !== 71'd0) begin bad++; $display("FAIL reset_payload: got %h/%h/%h/%h want 0", awaddr, wdata, wstrb, awprot); end
        total++; if ({seq, err_cnt, missed_cnt, timeout, busy} !== 34'd0) begin bad++; $display("FAIL reset_status: got seq=%0d err=%0d missed=%0d to=%b busy=%b want 0", seq, err_cnt, missed_cnt, timeout, busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        int t0;
        clear_logs();
        period = 32'd10; mask = 2'b11;
        t0 = cyc;
        enable = 1'b1;
        wait_writes(2, 60, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_burst1_timeout: got %0d writes want 2", w_log.size()); end
        total++; if ((aw_cyc_log[0] - t0) !== 10) begin bad++; $display("FAIL basic_first_latency: got %0d want 10", aw_cyc_log[0] - t0); end
        total++; if (aw_log[0] !== ADDR0 || aw_log[1] !== ADDR1) begin bad++; $display("FAIL basic_addrs: got %h,%h want %h,%h", aw_log[0], aw_log[1], ADDR0, ADDR1); end
        total++; if (w_log[0] !== 32'd1 || w_log[1] !== 32'd1) begin bad++; $display("FAIL basic_data1: got %0d,%0d want 1,1", w_log[0], w_log[1]); end
        total++; if ((aw_cyc_log[1] - aw_cyc_log[0]) !== 3) begin bad++; $display("FAIL basic_chan_spacing: got %0d want 3", aw_cyc_log[1] - aw_cyc_log[0]); end
        total++; if (seq !== 16'd1) begin bad++; $display("FAIL basic_seq1: got %0d want 1", seq); end
        wait_writes(4, 60, ok);
        enable = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL basic_burst2_timeout: got %0d writes want 4", w_log.size()); end
        total++; if ((aw_cyc_log[2] - aw_cyc_log[0]) !== 10) begin bad++; $display("FAIL basic_period: got %0d want 10", aw_cyc_log[2] - aw_cyc_log[0]); end
        total++; if (w_log[2] !== 32'd2 || w_log[3] !== 32'd2) begin bad++; $display("FAIL basic_data2: got %0d,%0d want 2,2", w_log[2], w_log[3]); end
        total++; if (seq !== 16'd2) begin bad++; $display("FAIL basic_seq2: got %0d want 2", seq); end
        total++; if (missed_cnt !== 8'd0) begin bad++; $display("FAIL basic_missed: got %0d want 0", missed_cnt); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_aw_delay();
        bit ok;
        clear_logs();
        aw_delay = 3; period = 32'd20; mask = 2'b11;
        enable = 1'b1;
        wait_writes(2, 100, ok);
        enable = 1'b0;
        aw_delay = 0;
        repeat (4) @(negedge clk);
        total++; if (!ok) begin bad++; $display("FAIL awdly_timeout: got %0d writes want 2", w_log.size()); end
        total++; if (aw_log.size() !== 2 || w_log.size() !== 2) begin bad++; $display("FAIL awdly_count: got aw=%0d w=%0d want 2,2", aw_log.size(), w_log.size()); end
        total++; if (aw_hold_log[0] !== 4 || aw_hold_log[1] !== 4) begin bad++; $display("FAIL awdly_aw_hold: got %0d,%0d want 4,4", aw_hold_log[0], aw_hold_log[1]); end
        total++; if (w_hold_log[0] !== 1 || w_hold_log[1] !== 1) begin bad++; $display("FAIL awdly_w_hold: got %0d,%0d want 1,1", w_hold_log[0], w_hold_log[1]); end
        total++; if (w_log[0] !== 32'd3 || seq !== 16'd3) begin bad++; $display("FAIL awdly_seq: got data=%0d seq=%0d want 3,3", w_log[0], seq); end
    endtask

    task automatic test_err();
        bit ok;
        clear_logs();
        err_ch1 = 1'b1; period = 32'd10; mask = 2'b11;
        enable = 1'b1;
        wait_writes(10, 200, ok);
        enable = 1'b0;
        err_ch1 = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL err_timeout: got %0d writes want 10", w_log.size()); end
        total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL err_count: got %0d want 5", err_cnt); end
        total++; if (timeout !== 1'b0) begin bad++; $display("FAIL err_no_timeout: got %b want 0", timeout); end
        total++; if (seq !== 16'd8 || w_log[8] !== 32'd8) begin bad++; $display("FAIL err_seq: got seq=%0d data=%0d want 8,8", seq, w_log[8]); end
        total++; if (missed_cnt !== 8'd0) begin bad++; $display("FAIL err_missed: got %0d want 0", missed_cnt); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall();
        bit ok;
        clear_logs();
        period = 32'd4; mask = 2'b01; b_delay = 20;
        enable = 1'b1;
        wait_writes(1, 100, ok);
        enable = 1'b0;
        b_delay = 0;
        total++; if (!ok) begin bad++; $display("FAIL stall_complete: got %0d writes busy=%b want 1 write, idle", w_log.size(), busy); end
        total++; if (missed_cnt !== 8'd5) begin bad++; $display("FAIL stall_missed: got %0d want 5", missed_cnt); end
        total++; if (timeout !== 1'b1) begin bad++; $display("FAIL stall_timeout: got %b want 1", timeout); end
        total++; if (seq !== 16'd9 || w_log[0] !== 32'd9 || aw_log[0] !== ADDR0) begin bad++; $display("FAIL stall_write: got seq=%0d data=%0d addr=%h want 9,9,%h", seq, w_log[0], aw_log[0], ADDR0); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_mask();
        bit ok;
        clear_logs();
        period = 32'd10; mask = 2'b10;
        enable = 1'b1;
        wait_writes(1, 60, ok);
        enable = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL mask_timeout: got %0d writes want 1", w_log.size()); end
        total++; if (aw_log.size() !== 1 || aw_log[0] !== ADDR1) begin bad++; $display("FAIL mask_addr: got n=%0d addr=%h want 1,%h", aw_log.size(), aw_log[0], ADDR1); end
        total++; if (w_log[0] !== 32'd10 || seq !== 16'd10) begin bad++; $display("FAIL mask_seq: got data=%0d seq=%0d want 10,10", w_log[0], seq); end
        mask = 2'b00;
        @(negedge clk);
        enable = 1'b1;
        repeat (35) @(negedge clk);
        enable = 1'b0;
        total++; if (aw_log.size() !== 1 || w_log.size() !== 1) begin bad++; $display("FAIL mask0_traffic: got aw=%0d w=%0d want 1,1", aw_log.size(), w_log.size()); end
        total++; if (missed_cnt !== 8'd5) begin bad++; $display("FAIL mask0_missed: got %0d want 5", missed_cnt); end
        total++; if (seq !== 16'd10 || busy !== 1'b0) begin bad++; $display("FAIL mask0_state: got seq=%0d busy=%b want 10,0", seq, busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        clear_logs();
        period = 32'd10; mask = 2'b01; b_delay = 20;
        enable = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bready) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_reach_resp: got bready=%b want 1", bready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (bready !== 1'b0 || busy !== 1'b0 || awvalid !== 1'b0) begin bad++; $display("FAIL rstmid_async: got bready=%b busy=%b awvalid=%b want 0", bready, busy, awvalid); end
        total++; if ({seq, err_cnt, missed_cnt, timeout} !== 33'd0) begin bad++; $display("FAIL rstmid_status: got seq=%0d err=%0d missed=%0d to=%b want 0", seq, err_cnt, missed_cnt, timeout); end
        b_delay = 0;
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        enable = 1'b1;
        wait_writes(1, 60, ok);
        enable = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL rstmid_restart: got %0d writes want 1", w_log.size()); end
        total++; if (w_log[0] !== 32'd1 || seq !== 16'd1) begin bad++; $display("FAIL rstmid_seq: got data=%0d seq=%0d want 1,1", w_log[0], seq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_aw_delay();
        test_err();
        test_stall();
        test_mask();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
